// File: rtl/alu_pkg.sv
// Shared ALU package: word/shift-amount widths and their types, used by the
// ALU submodules to pick their default parameterisation.
package alu_pkg;

  localparam int ALU_WORD_W  = 16;
  localparam int ALU_SHAMT_W = 4;

  typedef logic [ALU_WORD_W-1:0]  alu_word_t;
  typedef logic [ALU_SHAMT_W-1:0] alu_shamt_t;

endpackage : alu_pkg

// File: rtl/alu_sll_stage.sv
// One barrel-shifter stage: shifts left by 2**STAGE with zero fill when en is
// high, otherwise passes data through. With ALU_SLL_FLAGS_EN defined it also
// tracks the most recent bit pushed off the MSB end for the carry flag.
module alu_sll_stage #(
  parameter int WIDTH = 16,
  parameter int STAGE = 0
) (
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
`ifdef ALU_SLL_FLAGS_EN
  ,
  input  logic             carry_in,
  output logic             carry_out
`endif
);

  localparam int DIST = 1 << STAGE;

  // Conditional shift by DIST; vacated low bits are filled with zeros.
  always_comb begin
    data_out = data_in;
    if (en) begin
      data_out = {data_in[WIDTH-DIST-1:0], {DIST{1'b0}}};
    end
  end

`ifdef ALU_SLL_FLAGS_EN
  // The lowest bit leaving the word is the last one shifted out; stages run
  // in ascending order so the highest active stage sets the final carry.
  always_comb begin
    carry_out = carry_in;
    if (en) begin
      carry_out = data_in[WIDTH-DIST];
    end
  end
`endif

endmodule : alu_sll_stage

// File: rtl/alu_submodule_sll.sv
// Registered logical-shift-left unit: Answer = A << Shift (zero fill),
// presented one clock after in_valid, with a single-cycle out_valid strobe.
// Optional flags (carry_out, zero) exist only when ALU_SLL_FLAGS_EN is defined.
module alu_submodule_sll
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WORD_W,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] Shift,
  output logic [WIDTH-1:0]   Answer,
  output logic               out_valid
`ifdef ALU_SLL_FLAGS_EN
  ,
  output logic               carry_out,
  output logic               zero
`endif
);

  // The stage cascade only covers every shift amount when WIDTH == 2**SHAMT_W.
  if (WIDTH != (1 << SHAMT_W)) begin : g_param_check
    $error("alu_submodule_sll: WIDTH must equal 2**SHAMT_W");
  end

  logic [SHAMT_W:0][WIDTH-1:0] stage_data;
  assign stage_data[0] = A;

`ifdef ALU_SLL_FLAGS_EN
  logic [SHAMT_W:0] stage_carry;
  assign stage_carry[0] = 1'b0;
`endif

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    alu_sll_stage #(
      .WIDTH (WIDTH),
      .STAGE (k)
    ) u_stage (
      .en        (Shift[k]),
      .data_in   (stage_data[k]),
      .data_out  (stage_data[k+1])
`ifdef ALU_SLL_FLAGS_EN
      ,
      .carry_in  (stage_carry[k]),
      .carry_out (stage_carry[k+1])
`endif
    );
  end

  logic [WIDTH-1:0] shifted;
  assign shifted = stage_data[SHAMT_W];

  // Output register: loads only on in_valid so idle inputs (even X) never
  // reach the outputs; out_valid is a one-cycle strobe; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      Answer    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Answer <= shifted;
      end
    end
  end

`ifdef ALU_SLL_FLAGS_EN
  // Flag registers follow the same load/hold/reset rules as Answer.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else if (in_valid) begin
      carry_out <= stage_carry[SHAMT_W];
      zero      <= (shifted == '0);
    end
  end
`endif

endmodule : alu_submodule_sll

// File: tb/tb_alu_submodule_sll.sv
// Self-checking bench for alu_submodule_sll: directed cases with literal
// expectations, then randomized traffic checked every cycle against a
// wide-arithmetic reference model. Flags are checked when ALU_SLL_FLAGS_EN
// is defined.
module tb_alu_submodule_sll;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] A;
  logic [3:0]  Shift;
  logic [15:0] Answer;
  logic        out_valid;
`ifdef ALU_SLL_FLAGS_EN
  logic        carry_out;
  logic        zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_submodule_sll #(
    .WIDTH   (16),
    .SHAMT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .Shift     (Shift),
    .Answer    (Answer),
    .out_valid (out_valid)
`ifdef ALU_SLL_FLAGS_EN
    ,
    .carry_out (carry_out),
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkField(input string name, input logic [15:0] got,
                            input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, got, exp, $time);
    end
  endtask

  // Directed check of all outputs against hand-computed values.
  task automatic checkOutput(input string name, input logic [15:0] exp_ans,
                             input logic exp_valid, input logic exp_carry,
                             input logic exp_zero);
    checkField({name, ".Answer"}, Answer, exp_ans);
    checkField({name, ".out_valid"}, {15'd0, out_valid}, {15'd0, exp_valid});
`ifdef ALU_SLL_FLAGS_EN
    checkField({name, ".carry_out"}, {15'd0, carry_out}, {15'd0, exp_carry});
    checkField({name, ".zero"}, {15'd0, zero}, {15'd0, exp_zero});
`else
    if (exp_carry === 1'bx || exp_zero === 1'bx) begin
      $display("[TB] note: flag expectations unused in this build");
    end
`endif
  endtask

  // Drive one cycle of inputs, wait for the sampling edge, settle past it.
  task automatic applyStimulus(input logic v, input logic [15:0] a,
                               input logic [3:0] s, input logic r);
    in_valid = v;
    A        = a;
    Shift    = s;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the result is the low word of a wide A * 2**Shift, and
  // the last bit shifted out is bit 16 of that wide product.
  logic [15:0] m_ans;
  logic        m_valid;
  logic        m_carry;
  logic        m_zero;
  bit          m_init = 1'b0;

  always begin
    logic [31:0] wide;
    @(posedge clk);
    if (rst === 1'b1) begin
      m_ans   = 16'd0;
      m_valid = 1'b0;
      m_carry = 1'b0;
      m_zero  = 1'b0;
      m_init  = 1'b1;
    end else if (m_init) begin
      m_valid = (in_valid === 1'b1);
      if (in_valid === 1'b1) begin
        wide    = {16'd0, A} * (32'd1 << Shift);
        m_ans   = wide[15:0];
        m_carry = wide[16];
        m_zero  = (wide[15:0] == 16'd0);
      end
    end
    #2;
    if (m_init) begin
      checkField("model.Answer", Answer, m_ans);
      checkField("model.out_valid", {15'd0, out_valid}, {15'd0, m_valid});
`ifdef ALU_SLL_FLAGS_EN
      checkField("model.carry_out", {15'd0, carry_out}, {15'd0, m_carry});
      checkField("model.zero", {15'd0, zero}, {15'd0, m_zero});
`endif
    end
  end

  initial begin
    in_valid = 1'b0;
    A        = 16'd0;
    Shift    = 4'd0;
    rst      = 1'b1;

    applyStimulus(1'b0, 16'h0000, 4'd0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 4'd0, 1'b1);
    checkOutput("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'd15, 4'd2, 1'b0);
    checkOutput("15<<2", 16'd60, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h1234, 4'd5, 1'b0);
    checkOutput("hold_60", 16'd60, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'd10, 4'd0, 1'b0);
    checkOutput("10<<0", 16'd10, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd1, 4'd15, 1'b0);
    checkOutput("1<<15", 16'h8000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 4'd4, 1'b0);
    checkOutput("FFFF<<4", 16'hFFF0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h8000, 4'd1, 1'b0);
    checkOutput("8000<<1", 16'h0000, 1'b1, 1'b1, 1'b1);

    applyStimulus(1'b1, 16'd5, 4'd1, 1'b0);
    checkOutput("b2b_5<<1", 16'd10, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd3, 4'd3, 1'b0);
    checkOutput("b2b_3<<3", 16'd24, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00FF, 4'd8, 1'b0);
    checkOutput("b2b_FF<<8", 16'hFF00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'hxxxx, 4'bxxxx, 1'b0);
    checkOutput("idle_x_hold", 16'hFF00, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'd7, 4'd1, 1'b1);
    checkOutput("rst_vs_valid", 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd7, 4'd1, 1'b0);
    checkOutput("after_rst_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd7, 4'd1, 1'b0);
    checkOutput("fresh_7<<1", 16'd14, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic v;
      logic r;
      v = ($urandom_range(99) < 70);
      r = ($urandom_range(99) < 3);
      if (!v && $urandom_range(3) == 0) begin
        applyStimulus(1'b0, 16'hxxxx, 4'bxxxx, r);
      end else begin
        applyStimulus(v, 16'($urandom), 4'($urandom_range(15)), r);
      end
    end

    applyStimulus(1'b0, 16'h0000, 4'd0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 4'd0, 1'b0);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_submodule_sll
